// File: rtl/cache_mesi_pkg.sv
// Shared MESI types and the snoop transition rule used by the cache line controller.
package cache_mesi_pkg;

  typedef enum logic [1:0] {
    I = 2'd0,
    S = 2'd1,
    E = 2'd2,
    M = 2'd3
  } mesi_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    BUSRD   = 2'd1,
    BUSRDX  = 2'd2,
    BUSUPGR = 2'd3
  } bus_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_BUSREQ = 2'd2,
    ST_DONE   = 2'd3
  } fsm_t;

  typedef struct packed {
    mesi_t next;
    logic  flush;
  } snoop_res_t;

  // BusUpgr hitting an M line is a protocol error: drop the line without supplying data.
  function automatic snoop_res_t snoop_next(mesi_t cur, bus_cmd_t cmd);
    snoop_res_t r;
    r.next  = cur;
    r.flush = 1'b0;
    if (cur != I) begin
      case (cmd)
        BUSRD:   begin r.next = S; r.flush = (cur == M); end
        BUSRDX:  begin r.next = I; r.flush = (cur == M); end
        BUSUPGR: r.next = I;
        default: r.next = cur;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_mesi_ctrl_if.sv
// Processor, snoop and bus-arbiter signals of the MESI controller.
interface cache_mesi_ctrl_if #(
  parameter int NUM_LINES = 16
);
  localparam int IDX_W = $clog2(NUM_LINES);

  logic             pr_valid;
  logic             pr_wr;
  logic [IDX_W-1:0] pr_idx;
  logic             pr_ready;
  logic             pr_done;
  logic [1:0]       pr_state;

  logic [1:0]       sn_cmd;
  logic [IDX_W-1:0] sn_idx;
  logic             sn_flush;
  logic             sn_shared;

  logic             bus_req;
  logic [1:0]       bus_cmd;
  logic [IDX_W-1:0] bus_idx;
  logic             bus_gnt;
  logic             bus_c_in;

  // master is the controller, slave is the core/bus environment around it.
  modport master (
    input  pr_valid, pr_wr, pr_idx, sn_cmd, sn_idx, bus_gnt, bus_c_in,
    output pr_ready, pr_done, pr_state, sn_flush, sn_shared, bus_req, bus_cmd, bus_idx
  );

  modport slave (
    output pr_valid, pr_wr, pr_idx, sn_cmd, sn_idx, bus_gnt, bus_c_in,
    input  pr_ready, pr_done, pr_state, sn_flush, sn_shared, bus_req, bus_cmd, bus_idx
  );

endinterface

// File: rtl/mesi_state_array.sv
// Per-line MESI state storage: two combinational read ports, two write ports.
module mesi_state_array
  import cache_mesi_pkg::*;
#(
  parameter  int NUM_LINES = 16,
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [IDX_W-1:0] pr_ridx_i,
  output mesi_t            pr_rdata_o,
  input  logic [IDX_W-1:0] sn_ridx_i,
  output mesi_t            sn_rdata_o,
  input  logic             pr_we_i,
  input  logic [IDX_W-1:0] pr_widx_i,
  input  mesi_t            pr_wdata_i,
  input  logic             sn_we_i,
  input  logic [IDX_W-1:0] sn_widx_i,
  input  mesi_t            sn_wdata_i
);

  mesi_t mem_q [NUM_LINES];

  assign pr_rdata_o = mem_q[pr_ridx_i];
  assign sn_rdata_o = mem_q[sn_ridx_i];

  always_ff @(posedge clk) begin
    if (!rstb) begin
      // NOTE: every entry is reset, unlike a data RAM: a line must read I after reset.
      for (int i = 0; i < NUM_LINES; i++) mem_q[i] <= I;
    end else begin
      // Processor write comes last so it overrides a snoop write to the same line.
      if (sn_we_i) mem_q[sn_widx_i] <= sn_wdata_i;
      if (pr_we_i) mem_q[pr_widx_i] <= pr_wdata_i;
    end
  end

endmodule

// File: rtl/cache_mesi_ctrl.sv
// MESI controller for NUM_LINES lines: serves processor requests, arbitrates
// for the bus, and applies a snoop to any line every cycle.
module cache_mesi_ctrl
  import cache_mesi_pkg::*;
#(
  parameter int NUM_LINES = 16
) (
  input  logic              clk,
  input  logic              rstb,
  cache_mesi_ctrl_if.master io
);

  localparam int IDX_W = $clog2(NUM_LINES);

  fsm_t             state_q;
  logic             wr_q;
  logic [IDX_W-1:0] idx_q;
  bus_cmd_t         cmd_q;
  logic             bus_req_q;
  logic             pr_done_q;
  mesi_t            pr_state_q;
  logic             sn_flush_q;
  logic             sn_shared_q;

  mesi_t      pr_line;
  mesi_t      sn_line;
  bus_cmd_t   sn_cmd;
  snoop_res_t sn_res;
  logic       sn_same;
  logic       lookup_hit;
  mesi_t      grant_state;
  logic       pr_we_d;
  mesi_t      pr_wdata_d;

  assign sn_cmd      = bus_cmd_t'(io.sn_cmd);
  assign sn_res      = snoop_next(sn_line, sn_cmd);
  assign sn_same     = (sn_cmd != NONE) && (io.sn_idx == idx_q);
  assign lookup_hit  = wr_q ? (pr_line == M || pr_line == E) : (pr_line != I);
  assign grant_state = (cmd_q == BUSRD) ? (io.bus_c_in ? S : E) : M;

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    pr_we_d    = 1'b0;
    pr_wdata_d = pr_line;
    case (state_q)
      ST_LOOKUP: if (!sn_same && wr_q && pr_line == E) begin
        pr_we_d    = 1'b1;
        pr_wdata_d = M;
      end
      ST_BUSREQ: if (io.bus_gnt) begin
        pr_we_d    = 1'b1;
        pr_wdata_d = grant_state;
      end
      default: pr_we_d = 1'b0;
    endcase
  end

  mesi_state_array #(.NUM_LINES(NUM_LINES)) u_arr (
    .clk        (clk),
    .rstb       (rstb),
    .pr_ridx_i  (idx_q),
    .pr_rdata_o (pr_line),
    .sn_ridx_i  (io.sn_idx),
    .sn_rdata_o (sn_line),
    .pr_we_i    (pr_we_d),
    .pr_widx_i  (idx_q),
    .pr_wdata_i (pr_wdata_d),
    .sn_we_i    (sn_cmd != NONE),
    .sn_widx_i  (io.sn_idx),
    .sn_wdata_i (sn_res.next)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      cmd_q       <= NONE;
      bus_req_q   <= 1'b0;
      pr_done_q   <= 1'b0;
      pr_state_q  <= I;
      sn_flush_q  <= 1'b0;
      sn_shared_q <= 1'b0;
    end else begin
      sn_flush_q  <= sn_res.flush;
      sn_shared_q <= (sn_cmd != NONE) && (sn_line != I);
      pr_done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: if (io.pr_valid) begin
          wr_q    <= io.pr_wr;
          idx_q   <= io.pr_idx;
          state_q <= ST_LOOKUP;
        end
        ST_LOOKUP: if (!sn_same) begin
          if (lookup_hit) begin
            pr_done_q  <= 1'b1;
            pr_state_q <= wr_q ? M : pr_line;
            state_q    <= ST_DONE;
          end else begin
            bus_req_q <= 1'b1;
            cmd_q     <= !wr_q ? BUSRD : ((pr_line == S) ? BUSUPGR : BUSRDX);
            state_q   <= ST_BUSREQ;
          end
        end
        ST_BUSREQ: begin
          if (io.bus_gnt) begin
            bus_req_q  <= 1'b0;
            pr_done_q  <= 1'b1;
            pr_state_q <= grant_state;
            state_q    <= ST_DONE;
          end else if (cmd_q == BUSUPGR && sn_same && (sn_cmd == BUSRDX || sn_cmd == BUSUPGR)) begin
            // Our shared copy was invalidated before the upgrade won the bus.
            cmd_q <= BUSRDX;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign io.pr_ready  = (state_q == ST_IDLE);
  assign io.pr_done   = pr_done_q;
  assign io.pr_state  = pr_state_q;
  assign io.sn_flush  = sn_flush_q;
  assign io.sn_shared = sn_shared_q;
  assign io.bus_req   = bus_req_q;
  assign io.bus_cmd   = cmd_q;
  assign io.bus_idx   = idx_q;

endmodule
